vpu_tile_scheduler: RTL

Sequencer for the tiled vector unit that runs a full C = A × W matrix multiply, tile by tile. It iterates tile indices i (row tiles of A/C), j (column tiles of W/C) and k (reduction tiles). For each tile it drives load_a/load_w bursts into the operand RAM, holds compute until the datapath reports completion, then issues a deload_out burst to write the result tile. It sits between the top-level start/done handshake and the ram/vpu_top pair, replacing their free-running internal sequencing.

---
 rtl/vpu_tile_scheduler_pkg.sv | 32 +++
 rtl/vpu_tile_scheduler_tile_addr_gen.sv | 36 +++
 rtl/vpu_tile_scheduler.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vpu_tile_scheduler_pkg.sv
// Shared definitions for the tiled matmul scheduler: FSM states, default tile
// geometry and width helpers.
package vpu_tile_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_W,
    S_COMPUTE,
    S_STORE,
    S_DONE
  } sched_state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_TILE       = 4;
  localparam int unsigned DEF_M_TILES    = 2;
  localparam int unsigned DEF_K_TILES    = 2;
  localparam int unsigned DEF_N_TILES    = 2;

  // A counter for a single-valued range still needs one bit to be a legal port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vpu_tile_scheduler_tile_addr_gen.sv
// Combinational RAM address generation from the current tile indices and row;
// results wrap modulo 2^ADDR_WIDTH.
module tile_addr_gen
  import vpu_tile_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TILE       = DEF_TILE,
  parameter int unsigned K_TILES    = DEF_K_TILES,
  parameter int unsigned N_TILES    = DEF_N_TILES,
  parameter int unsigned IDX_W      = 1,
  parameter int unsigned ROW_W      = 2
) (
  input  logic [IDX_W-1:0]      index_i,
  input  logic [IDX_W-1:0]      index_j,
  input  logic [IDX_W-1:0]      index_k,
  input  logic [ROW_W-1:0]      row,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [ADDR_WIDTH-1:0] addr_res
);

  logic [31:0] full_a;
  logic [31:0] full_w;
  logic [31:0] full_res;

  always_comb begin
    full_a   = (32'(index_i) * K_TILES + 32'(index_k)) * TILE + 32'(row);
    full_w   = (32'(index_k) * N_TILES + 32'(index_j)) * TILE + 32'(row);
    full_res = (32'(index_i) * N_TILES + 32'(index_j)) * TILE + 32'(row);
  end

  assign addr_a   = full_a[ADDR_WIDTH-1:0];
  assign addr_w   = full_w[ADDR_WIDTH-1:0];
  assign addr_res = full_res[ADDR_WIDTH-1:0];

endmodule

// File: rtl/vpu_tile_scheduler.sv
// Tile sequencer for C = A x W: load A rows, load W rows, wait for the MAC,
// and after the last reduction tile store the result rows.
module vpu_tile_scheduler
  import vpu_tile_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned TILE       = DEF_TILE,
  parameter int unsigned M_TILES    = DEF_M_TILES,
  parameter int unsigned K_TILES    = DEF_K_TILES,
  parameter int unsigned N_TILES    = DEF_N_TILES,
  localparam int unsigned IDX_W     = idx_width(max3(M_TILES, K_TILES, N_TILES)),
  localparam int unsigned ROW_W     = idx_width(TILE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  compute_done,
  output logic                  busy,
  output logic                  done,
  output logic                  load_a,
  output logic                  load_w,
  output logic                  compute,
  output logic                  acc_clear,
  output logic                  deload_out,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [ADDR_WIDTH-1:0] addr_res,
  output logic [IDX_W-1:0]      index_i,
  output logic [IDX_W-1:0]      index_j,
  output logic [IDX_W-1:0]      index_k,
  output logic [ROW_W-1:0]      row
);

  localparam logic [IDX_W-1:0] I_LAST   = IDX_W'(M_TILES - 1);
  localparam logic [IDX_W-1:0] J_LAST   = IDX_W'(N_TILES - 1);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(K_TILES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE - 1);

  sched_state_t state;

  logic [ADDR_WIDTH-1:0] raw_a;
  logic [ADDR_WIDTH-1:0] raw_w;
  logic [ADDR_WIDTH-1:0] raw_res;

  tile_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TILE       (TILE),
    .K_TILES    (K_TILES),
    .N_TILES    (N_TILES),
    .IDX_W      (IDX_W),
    .ROW_W      (ROW_W)
  ) u_addr_gen (
    .index_i  (index_i),
    .index_j  (index_j),
    .index_k  (index_k),
    .row      (row),
    .addr_a   (raw_a),
    .addr_w   (raw_w),
    .addr_res (raw_res)
  );

  // Addresses idle at zero outside their own burst.
  assign addr_a   = load_a     ? raw_a   : '0;
  assign addr_w   = load_w     ? raw_w   : '0;
  assign addr_res = deload_out ? raw_res : '0;

  // Strobes are registered alongside the state so each one lines up with the
  // cycle its state is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_a     <= 1'b0;
      load_w     <= 1'b0;
      compute    <= 1'b0;
      acc_clear  <= 1'b0;
      deload_out <= 1'b0;
      index_i    <= '0;
      index_j    <= '0;
      index_k    <= '0;
      row        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            index_i <= '0;
            index_j <= '0;
            index_k <= '0;
            row     <= '0;
            busy    <= 1'b1;
            load_a  <= 1'b1;
            state   <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (row == ROW_LAST) begin
            row    <= '0;
            load_a <= 1'b0;
            load_w <= 1'b1;
            state  <= S_LOAD_W;
          end else begin
            row <= row + 1'b1;
          end
        end
        S_LOAD_W: begin
          if (row == ROW_LAST) begin
            row       <= '0;
            load_w    <= 1'b0;
            compute   <= 1'b1;
            acc_clear <= (index_k == '0);
            state     <= S_COMPUTE;
          end else begin
            row <= row + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (compute_done) begin
            compute   <= 1'b0;
            acc_clear <= 1'b0;
            if (index_k != K_LAST) begin
              index_k <= index_k + 1'b1;
              load_a  <= 1'b1;
              state   <= S_LOAD_A;
            end else begin
              deload_out <= 1'b1;
              state      <= S_STORE;
            end
          end
        end
        S_STORE: begin
          if (row == ROW_LAST) begin
            row        <= '0;
            deload_out <= 1'b0;
            index_k    <= '0;
            if (index_j == J_LAST) begin
              index_j <= '0;
              index_i <= (index_i == I_LAST) ? '0 : index_i + 1'b1;
            end else begin
              index_j <= index_j + 1'b1;
            end
            if (index_i == I_LAST && index_j == J_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              load_a <= 1'b1;
              state  <= S_LOAD_A;
            end
          end else begin
            row <= row + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy       <= 1'b0;
          load_a     <= 1'b0;
          load_w     <= 1'b0;
          compute    <= 1'b0;
          acc_clear  <= 1'b0;
          deload_out <= 1'b0;
          row        <= '0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
